// File: rtl/dff_mem_bank.sv
// dff_mem_bank: parametrised flip-flop memory with registered reads and a hardware clear sweep.
module dff_mem_bank #(
  parameter int                DATA_W  = 8,
  parameter int                ADDR_W  = 4,
  parameter int                DEPTH   = 16,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_n,
  input  logic              lr_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              data_oe,
  output logic              busy
);
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d, oe_q, oe_d;
  logic                idle, last, acc, in_range, rd, ld, wr;
  assign idle     = state_q == IDLE;
  assign last     = ptr_q == LAST;
  assign in_range = {1'b0, addr} < DEPTH_L;
  // clr has priority over any access presented in the same cycle
  assign acc      = idle && !clr && !ce_n;
  assign rd       = acc && lr_n;
  assign ld       = acc && !lr_n;
  assign wr       = ld && in_range;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  always_comb begin
    state_d = idle ? (clr ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
    ptr_d   = (idle || last) ? '0 : ptr_q + 1'b1;
  end
  always_comb begin
    rdata_d  = rd ? (in_range ? mem_q[addr] : '0) : rdata_q;
    rvalid_d = rd;
    oe_d     = rd ? 1'b1 : (ld ? 1'b0 : oe_q);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      if (!idle) mem_q[ptr_q] <= CLR_VAL;
      else if (wr) mem_q[addr] <= wdata;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      oe_q     <= oe_d;
    end
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign data_oe = oe_q;
  assign busy    = state_q == CLEAR;
endmodule

// File: tb/tb_dff_mem_bank.sv
// tb_dff_mem_bank: directed vector table plus hand sequences for reset, clear sweep and short-depth instance.
module tb_dff_mem_bank;
  logic       clk = 0, rst = 1, ce_n = 1, lr_n = 1, clr = 0;
  logic [3:0] addr = 0;
  logic [7:0] wdata = 0;
  logic [7:0] rdata_a, rdata_b;
  logic       rvalid_a, rvalid_b, oe_a, oe_b, busy_a, busy_b;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  dff_mem_bank #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .CLR_VAL(8'hC3)) dut_a (
    .clk(clk), .rst(rst), .ce_n(ce_n), .lr_n(lr_n), .addr(addr), .wdata(wdata), .clr(clr),
    .rdata(rdata_a), .rvalid(rvalid_a), .data_oe(oe_a), .busy(busy_a));

  dff_mem_bank #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .CLR_VAL(8'h5A)) dut_b (
    .clk(clk), .rst(rst), .ce_n(ce_n), .lr_n(lr_n), .addr(addr), .wdata(wdata), .clr(clr),
    .rdata(rdata_b), .rvalid(rvalid_b), .data_oe(oe_b), .busy(busy_b));

  typedef struct {
    logic       ce_n, lr_n;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid, oe, busy;
  } vec_t;

  vec_t vecs [14];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    ce_n = 0; lr_n = 0; addr = a; wdata = d;
    cyc();
  endtask

  task automatic rd(input logic [3:0] a);
    ce_n = 0; lr_n = 1; addr = a;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt_a, cnt_b;
    vecs[0]  = '{1, 1, 4'd0,  8'h00, 8'h00, 0, 0, 0};
    vecs[1]  = '{0, 0, 4'd0,  8'hAA, 8'h00, 0, 0, 0};
    vecs[2]  = '{0, 0, 4'd15, 8'h55, 8'h00, 0, 0, 0};
    vecs[3]  = '{0, 1, 4'd0,  8'h00, 8'hAA, 1, 1, 0};
    vecs[4]  = '{0, 1, 4'd15, 8'h00, 8'h55, 1, 1, 0};
    vecs[5]  = '{1, 1, 4'd0,  8'h00, 8'h55, 0, 1, 0};
    vecs[6]  = '{1, 0, 4'd3,  8'hEE, 8'h55, 0, 1, 0};
    vecs[7]  = '{1, 1, 4'd7,  8'h00, 8'h55, 0, 1, 0};
    vecs[8]  = '{0, 0, 4'd3,  8'h11, 8'h55, 0, 0, 0};
    vecs[9]  = '{0, 1, 4'd3,  8'h00, 8'h11, 1, 1, 0};
    vecs[10] = '{0, 1, 4'd1,  8'h00, 8'h00, 1, 1, 0};
    vecs[11] = '{0, 0, 4'd1,  8'h22, 8'h00, 0, 0, 0};
    vecs[12] = '{0, 1, 4'd1,  8'h00, 8'h22, 1, 1, 0};
    vecs[13] = '{1, 0, 4'd1,  8'h99, 8'h22, 0, 1, 0};

    repeat (2) cyc();
    rst = 0;
    for (int i = 0; i < 14; i++) begin
      ce_n = vecs[i].ce_n; lr_n = vecs[i].lr_n; addr = vecs[i].addr; wdata = vecs[i].wdata;
      cyc();
      chk($sformatf("vec%0d", i), {rdata_a, rvalid_a, oe_a, busy_a},
          {vecs[i].rdata, vecs[i].rvalid, vecs[i].oe, vecs[i].busy});
    end

    rd(4'd3);
    #2 rst = 1;
    #1;
    chk("async_rst_a", {rdata_a, rvalid_a, oe_a, busy_a}, 0);
    chk("async_rst_b", {rdata_b, rvalid_b, oe_b, busy_b}, 0);
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk($sformatf("rst_rd%0d", i), {rdata_a, rvalid_a}, {8'h00, 1'b1});
    end

    for (int i = 0; i < 16; i++) wr(4'(i), 8'(i * 17 + 1));
    rd(4'd5);
    chk("fill_rd5", rdata_a, 8'h56);
    clr = 1; ce_n = 0; lr_n = 0; addr = 4'd5; wdata = 8'h77;
    cyc();
    clr = 0; lr_n = 1;
    cnt_a = 0; cnt_b = 0;
    while ((busy_a || busy_b) && cnt_a < 40) begin
      if (busy_a) begin
        cnt_a++;
        chk("busy_rvalid", rvalid_a, 0);
      end
      if (busy_b) cnt_b++;
      cyc();
    end
    chk("clr_len_a", cnt_a, 16);
    chk("clr_len_b", cnt_b, 12);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk($sformatf("clr_rd%0d", i), {rdata_a, rvalid_a}, {8'hC3, 1'b1});
    end

    ce_n = 1; clr = 1;
    cyc();
    clr = 0;
    repeat (6) cyc();
    chk("mid_clr_busy", busy_a, 1);
    #2 rst = 1;
    #1;
    chk("mid_clr_rst", {busy_a, busy_b}, 0);
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk($sformatf("abort_rd%0d", i), {rdata_a, rvalid_a}, {8'h00, 1'b1});
    end
    ce_n = 1; clr = 1;
    cyc();
    clr = 0;
    cnt_a = 0; cnt_b = 0;
    while ((busy_a || busy_b) && cnt_a < 40) begin
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
      cyc();
    end
    chk("clr2_len_a", cnt_a, 16);
    chk("clr2_len_b", cnt_b, 12);

    wr(4'd13, 8'h99);
    rd(4'd11);
    chk("b_rd11", {rdata_b, rvalid_b}, {8'h5A, 1'b1});
    chk("a_rd11", {rdata_a, rvalid_a}, {8'hC3, 1'b1});
    rd(4'd13);
    chk("b_rd13_oor", {rdata_b, rvalid_b, oe_b}, {8'h00, 1'b1, 1'b1});
    chk("a_rd13", {rdata_a, rvalid_a}, {8'h99, 1'b1});
    ce_n = 1;
    cyc();
    chk("b_idle", {rdata_b, rvalid_b}, {8'h00, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
